// File: rtl/cva6_cfg_info_responder.sv
// ============================================================================
// Module   : cva6_cfg_info_responder
// Purpose  : Read-only 8-word table exposing the elaborated core configuration
//            over valid/ready request/response channels with an in-order FIFO.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cva6_cfg_info_responder #(
    parameter int unsigned NrCommitPorts       = 1,
    parameter int unsigned NrScoreboardEntries = 4,
    parameter logic [31:0] ExtMask             = 32'h0000_0386,
    parameter int unsigned IcacheByteSize      = 16384,
    parameter int unsigned DcacheByteSize      = 32768,
    parameter int unsigned IcacheSetAssoc      = 4,
    parameter int unsigned DcacheSetAssoc      = 8,
    parameter int unsigned NrPMPEntries        = 8,
    parameter int unsigned XLEN                = 32,
    parameter int unsigned IdWidth             = 4,
    parameter int unsigned RspDepth            = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [7:0]         req_addr_i,
    input  logic [IdWidth-1:0] req_id_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [31:0]        rsp_data_o,
    output logic               rsp_err_o,
    output logic [IdWidth-1:0] rsp_id_o,
    output logic [7:0]         err_cnt_o
);

    localparam int unsigned PTR_W = (RspDepth > 1) ? $clog2(RspDepth) : 1;
    localparam int unsigned CNT_W = $clog2(RspDepth + 1);
    localparam int unsigned ENT_W = 32 + 1 + IdWidth;

    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic [ENT_W-1:0] mem_q [RspDepth];

    logic             push;
    logic             pop;
    logic             addr_err;
    logic [31:0]      rd_data;
    logic [ENT_W-1:0] head;

    // Table lookup; only sampled into the FIFO on acceptance, so X addresses
    // while idle never reach the outputs.
    always_comb begin
        addr_err = (req_addr_i[1:0] != 2'b00) || (req_addr_i >= 8'h20);
        rd_data  = '0;
        case (req_addr_i[4:2])
            3'd0: rd_data = 32'h4356_3643;
            3'd1: rd_data = {16'h0001, 8'(NrCommitPorts), 8'(NrScoreboardEntries)};
            3'd2: rd_data = ExtMask;
            3'd3: rd_data = 32'(IcacheByteSize);
            3'd4: rd_data = 32'(DcacheByteSize);
            3'd5: rd_data = {16'(IcacheSetAssoc), 16'(DcacheSetAssoc)};
            3'd6: rd_data = {24'h0, 8'(NrPMPEntries)};
            3'd7: rd_data = 32'(XLEN);
            default: rd_data = '0;
        endcase
        if (addr_err) begin
            rd_data = '0;
        end
    end

    assign req_ready_o = (count_q < CNT_W'(RspDepth));
    assign rsp_valid_o = (count_q != '0);
    assign push        = req_valid_i & req_ready_o;
    assign pop         = rsp_valid_o & rsp_ready_i;

    always_comb begin
        count_d   = count_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        err_cnt_d = err_cnt_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(RspDepth - 1)) ? '0 : wr_ptr_q + 1'b1;
            if (addr_err && (err_cnt_q != 8'hFF)) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(RspDepth - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Storage needs no reset: an entry is only visible while count_q covers it.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {rd_data, addr_err, req_id_i};
        end
    end

    assign head       = rsp_valid_o ? mem_q[rd_ptr_q] : '0;
    assign rsp_data_o = head[ENT_W-1 -: 32];
    assign rsp_err_o  = head[IdWidth];
    assign rsp_id_o   = head[IdWidth-1:0];
    assign err_cnt_o  = err_cnt_q;

endmodule

`default_nettype wire
